// File: rtl/ifu_imem_pkg.sv
// Shared definitions for the instruction-fetch memory controller: widths,
// FSM state encoding and the reset PC seen by the PC register upstream.
package ifu_imem_pkg;

    localparam int CPU_WIDTH_DEF  = 32;
    localparam int INST_WIDTH_DEF = 32;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } imem_state_e;

    // Instruction fetches must be 4-byte aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_imem_stl_reg.sv
// Generic enabled register with synchronous active-low reset; used for each
// field of the fetch output slot.
module stl_reg #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            qout <= RST_VAL;
        else if (wen)
            qout <= din;
    end

endmodule

// File: rtl/ifu_imem.sv
// Instruction-memory fetch controller: one outstanding word read per PC,
// result held in a valid/ready slot, redirect flushes drop in-flight data.
module ifu_imem
    import ifu_imem_pkg::*;
#(
    parameter int CPU_WIDTH  = CPU_WIDTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [CPU_WIDTH-1:0]  i_pc,
    output logic                  o_ifu_wen,
    input  logic                  i_flush,
    output logic                  o_imem_req,
    output logic [CPU_WIDTH-1:0]  o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [INST_WIDTH-1:0] i_imem_rdata,
    input  logic                  i_imem_err,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0]  o_inst_pc,
    output logic                  o_inst_err
);

    imem_state_e          state_q, state_d;
    logic                 drop_q, drop_d;
    logic [CPU_WIDTH-1:0] addr_q, addr_d;

    logic                  slot_en;
    logic [INST_WIDTH-1:0] slot_inst_d;
    logic [CPU_WIDTH-1:0]  slot_pc_d;
    logic                  slot_err_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        addr_d      = addr_q;
        slot_en     = 1'b0;
        slot_inst_d = '0;
        slot_pc_d   = addr_q;
        slot_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!i_flush) begin
                    if (pc_misaligned(i_pc[1:0])) begin
                        // Fault is reported through the slot without touching the bus.
                        slot_en    = 1'b1;
                        slot_pc_d  = i_pc;
                        slot_err_d = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        addr_d  = {i_pc[CPU_WIDTH-1:2], 2'b00};
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // The request cannot be withdrawn, so a flush only marks it for dropping.
                if (i_flush)
                    drop_d = 1'b1;
                if (i_imem_gnt)
                    state_d = (drop_q || i_flush) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (i_flush) begin
                    state_d = i_imem_rvalid ? S_IDLE : S_DRAIN;
                end else if (i_imem_rvalid) begin
                    slot_en     = 1'b1;
                    slot_inst_d = i_imem_rdata;
                    slot_pc_d   = addr_q;
                    slot_err_d  = i_imem_err;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_flush || i_inst_ready)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (i_imem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    assign o_imem_req   = (state_q == S_REQ);
    assign o_imem_addr  = addr_q;
    assign o_inst_valid = (state_q == S_HOLD);
    assign o_ifu_wen    = ((state_q == S_HOLD) && i_inst_ready) || i_flush;

    stl_reg #(.DW(INST_WIDTH)) u_slot_inst (
        .clk   (i_clk),
        .rst_n (i_rst),
        .wen   (slot_en),
        .din   (slot_inst_d),
        .qout  (o_inst)
    );

    stl_reg #(.DW(CPU_WIDTH)) u_slot_pc (
        .clk   (i_clk),
        .rst_n (i_rst),
        .wen   (slot_en),
        .din   (slot_pc_d),
        .qout  (o_inst_pc)
    );

    stl_reg #(.DW(1)) u_slot_err (
        .clk   (i_clk),
        .rst_n (i_rst),
        .wen   (slot_en),
        .din   (slot_err_d),
        .qout  (o_inst_err)
    );

endmodule
